// File: rtl/rvfi_cmp_pkg.sv
// Shared types for the RVFI-vs-reference-model comparator: FSM states,
// the retirement record carried through the FIFO, and mismatch bit indices.
package rvfi_cmp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NFIELDS = 6;

  localparam int unsigned MISM_PC       = 0;
  localparam int unsigned MISM_INSN     = 1;
  localparam int unsigned MISM_RD_ADDR  = 2;
  localparam int unsigned MISM_RD_WDATA = 3;
  localparam int unsigned MISM_TRAP     = 4;
  localparam int unsigned MISM_ORDER    = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CMP,
    HALT
  } rvfi_cmp_state_e;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            trap;
  } rvfi_cmp_entry_t;

  // The model record carries the expected order, so the order-gap check is a plain field compare.
  function automatic logic [NFIELDS-1:0] cmp_fields(input rvfi_cmp_entry_t core,
                                                    input rvfi_cmp_entry_t model);
    logic [NFIELDS-1:0] f;
    f = '0;
    f[MISM_PC]    = (core.pc != model.pc);
    f[MISM_TRAP]  = (core.trap != model.trap);
    f[MISM_ORDER] = (core.order != model.order);
    if (!(core.trap && model.trap)) begin
      f[MISM_INSN]     = (core.insn != model.insn);
      f[MISM_RD_ADDR]  = (core.rd_addr != model.rd_addr);
      f[MISM_RD_WDATA] = (core.rd_addr != 5'd0) && (core.rd_wdata != model.rd_wdata);
    end
    return f;
  endfunction

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// Synchronous FIFO of retirement records; the caller guarantees push only when
// there is room (or a pop happens in the same cycle) and pop only when non-empty.
module rvfi_cmp_fifo
  import rvfi_cmp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic            pop,
  input  rvfi_cmp_entry_t wr_entry,
  output rvfi_cmp_entry_t head_c,
  output logic            full_c,
  output logic            empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rvfi_cmp_entry_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == (AW+1)'(DEPTH));
  assign empty_c = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/rvfi_ref_compare.sv
// Buffers core retirements, steps the reference model once per entry and
// compares the two records, reporting first mismatch, sticky flags and a count.
module rvfi_ref_compare
  import rvfi_cmp_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TIMEOUT      = 1024,
  parameter bit          STOP_ON_MISM = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_valid_i,
  input  logic [63:0]        core_order_i,
  input  logic [XLEN-1:0]    core_pc_i,
  input  logic [31:0]        core_insn_i,
  input  logic [4:0]         core_rd_addr_i,
  input  logic [XLEN-1:0]    core_rd_wdata_i,
  input  logic               core_trap_i,
  output logic               ref_req_o,
  input  logic               ref_valid_i,
  input  logic [XLEN-1:0]    ref_pc_i,
  input  logic [31:0]        ref_insn_i,
  input  logic [4:0]         ref_rd_addr_i,
  input  logic [XLEN-1:0]    ref_rd_wdata_i,
  input  logic               ref_trap_i,
  output logic               mismatch_o,
  output logic [NFIELDS-1:0] mism_fields_o,
  output logic [63:0]        mism_order_o,
  output logic [31:0]        compared_cnt_o,
  output logic               overflow_o,
  output logic               timeout_o,
  output logic               halted_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  rvfi_cmp_state_e    state;
  logic [CW-1:0]      wait_cnt;
  rvfi_cmp_entry_t    core_entry_c;
  rvfi_cmp_entry_t    head_c;
  rvfi_cmp_entry_t    cap;
  logic [63:0]        prev_order;
  logic               prev_valid;
  logic               push_c;
  logic               pop_c;
  logic               full_c;
  logic               empty_c;
  logic [NFIELDS-1:0] fields_c;

  always_comb begin
    core_entry_c.order    = core_order_i;
    core_entry_c.pc       = core_pc_i;
    core_entry_c.insn     = core_insn_i;
    core_entry_c.rd_addr  = core_rd_addr_i;
    core_entry_c.rd_wdata = core_rd_wdata_i;
    core_entry_c.trap     = core_trap_i;
  end

  assign pop_c    = (state == CMP);
  assign push_c   = core_valid_i && (!full_c || pop_c);
  assign fields_c = cmp_fields(head_c, cap);

  rvfi_cmp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push_c),
    .pop      (pop_c),
    .wr_entry (core_entry_c),
    .head_c   (head_c),
    .full_c   (full_c),
    .empty_c  (empty_c)
  );

  // Step/compare FSM with all reporting registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cap            <= '0;
      prev_order     <= '0;
      prev_valid     <= 1'b0;
      ref_req_o      <= 1'b0;
      mismatch_o     <= 1'b0;
      mism_fields_o  <= '0;
      mism_order_o   <= '0;
      compared_cnt_o <= '0;
      overflow_o     <= 1'b0;
      timeout_o      <= 1'b0;
      halted_o       <= 1'b0;
    end else begin
      ref_req_o <= 1'b0;
      if (core_valid_i && !push_c) overflow_o <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty_c) begin
            state     <= REQ;
            ref_req_o <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (ref_valid_i) begin
            // Expected order is stored in the capture so the first compare is exempt.
            cap.order    <= prev_valid ? (prev_order + 64'd1) : head_c.order;
            cap.pc       <= ref_pc_i;
            cap.insn     <= ref_insn_i;
            cap.rd_addr  <= ref_rd_addr_i;
            cap.rd_wdata <= ref_rd_wdata_i;
            cap.trap     <= ref_trap_i;
            state        <= CMP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            timeout_o <= 1'b1;
            halted_o  <= 1'b1;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        CMP: begin
          if (compared_cnt_o != 32'hFFFF_FFFF) compared_cnt_o <= compared_cnt_o + 32'd1;
          prev_order <= head_c.order;
          prev_valid <= 1'b1;
          if (|fields_c) begin
            mismatch_o <= 1'b1;
            if (!mismatch_o) begin
              mism_fields_o <= fields_c;
              mism_order_o  <= head_c.order;
            end
          end
          if ((|fields_c) && STOP_ON_MISM) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_ref_compare.sv
// Scoreboard bench: two comparators (halt-on-mismatch and continue) share the core
// stream; a reference responder per instance answers step requests.
module tb_rvfi_ref_compare;
  import rvfi_cmp_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;

  typedef struct {
    logic [31:0] cnt;
    logic        mism;
    logic [5:0]  fields;
    logic [63:0] order;
    logic        halt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            core_valid;
  logic [63:0]     core_order;
  logic [XLEN-1:0] core_pc;
  logic [31:0]     core_insn;
  logic [4:0]      core_rd_addr;
  logic [XLEN-1:0] core_rd_wdata;
  logic            core_trap;

  logic            ref_req      [2];
  logic            ref_valid    [2];
  logic [XLEN-1:0] ref_pc       [2];
  logic [31:0]     ref_insn     [2];
  logic [4:0]      ref_rd_addr  [2];
  logic [XLEN-1:0] ref_rd_wdata [2];
  logic            ref_trap     [2];
  logic            mismatch     [2];
  logic [5:0]      mism_fields  [2];
  logic [63:0]     mism_order   [2];
  logic [31:0]     cnt          [2];
  logic            overflow     [2];
  logic            timeout      [2];
  logic            halted       [2];

  rvfi_ref_compare #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_MISM(1'b1)) dut_stop (
    .clk_i(clk), .rst_i(rst), .core_valid_i(core_valid), .core_order_i(core_order),
    .core_pc_i(core_pc), .core_insn_i(core_insn), .core_rd_addr_i(core_rd_addr),
    .core_rd_wdata_i(core_rd_wdata), .core_trap_i(core_trap), .ref_req_o(ref_req[0]),
    .ref_valid_i(ref_valid[0]), .ref_pc_i(ref_pc[0]), .ref_insn_i(ref_insn[0]),
    .ref_rd_addr_i(ref_rd_addr[0]), .ref_rd_wdata_i(ref_rd_wdata[0]), .ref_trap_i(ref_trap[0]),
    .mismatch_o(mismatch[0]), .mism_fields_o(mism_fields[0]), .mism_order_o(mism_order[0]),
    .compared_cnt_o(cnt[0]), .overflow_o(overflow[0]), .timeout_o(timeout[0]), .halted_o(halted[0])
  );

  rvfi_ref_compare #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_MISM(1'b0)) dut_cont (
    .clk_i(clk), .rst_i(rst), .core_valid_i(core_valid), .core_order_i(core_order),
    .core_pc_i(core_pc), .core_insn_i(core_insn), .core_rd_addr_i(core_rd_addr),
    .core_rd_wdata_i(core_rd_wdata), .core_trap_i(core_trap), .ref_req_o(ref_req[1]),
    .ref_valid_i(ref_valid[1]), .ref_pc_i(ref_pc[1]), .ref_insn_i(ref_insn[1]),
    .ref_rd_addr_i(ref_rd_addr[1]), .ref_rd_wdata_i(ref_rd_wdata[1]), .ref_trap_i(ref_trap[1]),
    .mismatch_o(mismatch[1]), .mism_fields_o(mism_fields[1]), .mism_order_o(mism_order[1]),
    .compared_cnt_o(cnt[1]), .overflow_o(overflow[1]), .timeout_o(timeout[1]), .halted_o(halted[1])
  );

  int total = 0;
  int bad   = 0;

  exp_t            exp_q [2][$];
  rvfi_cmp_entry_t ref_q [2][$];

  logic [63:0] m_prev      [2];
  bit          m_have_prev [2];
  int unsigned m_cnt       [2];
  bit          m_mism      [2];
  logic [5:0]  m_fields    [2];
  logic [63:0] m_order     [2];
  bit          m_halt      [2];
  int          pushed      [2];
  int          popped      [2];
  bit          auto_on     [2];
  int          req_cnt     [2];
  time         req_time    [2];
  logic        prev_req    [2];
  logic [31:0] last_cnt    [2];

  function automatic bit stop_of(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  function automatic rvfi_cmp_entry_t mk(input logic [63:0] order, input logic [31:0] pc,
                                         input logic [31:0] insn, input logic [4:0] rd,
                                         input logic [31:0] wd, input logic trap);
    rvfi_cmp_entry_t e;
    e.order = order; e.pc = pc; e.insn = insn; e.rd_addr = rd; e.rd_wdata = wd; e.trap = trap;
    return e;
  endfunction

  // Compare rules stated directly: which fields disagree between core and reference.
  function automatic logic [5:0] expect_fields(input rvfi_cmp_entry_t c, input rvfi_cmp_entry_t r,
                                               input bit have_prev, input logic [63:0] prev);
    logic [5:0] f;
    f = 6'd0;
    if (c.pc != r.pc) f[0] = 1'b1;
    if (c.trap != r.trap) f[4] = 1'b1;
    if (!(c.trap && r.trap)) begin
      if (c.insn != r.insn) f[1] = 1'b1;
      if (c.rd_addr != r.rd_addr) f[2] = 1'b1;
      if (c.rd_addr != 5'd0 && c.rd_wdata != r.rd_wdata) f[3] = 1'b1;
    end
    if (have_prev && c.order != prev + 64'd1) f[5] = 1'b1;
    return f;
  endfunction

  // Drive one retirement for one cycle; when tracked, record expected compare outcome per instance.
  task automatic retire(input rvfi_cmp_entry_t c, input rvfi_cmp_entry_t r, input bit track);
    logic [5:0] f;
    exp_t e;
    core_valid = 1'b1; core_order = c.order; core_pc = c.pc; core_insn = c.insn;
    core_rd_addr = c.rd_addr; core_rd_wdata = c.rd_wdata; core_trap = c.trap;
    if (track) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_halt[i]) begin
          f = expect_fields(c, r, m_have_prev[i], m_prev[i]);
          m_cnt[i]++;
          if (f != 6'd0 && !m_mism[i]) begin
            m_mism[i] = 1'b1; m_fields[i] = f; m_order[i] = c.order;
          end
          if (f != 6'd0 && stop_of(i)) m_halt[i] = 1'b1;
          e.cnt = m_cnt[i]; e.mism = m_mism[i]; e.fields = m_fields[i];
          e.order = m_order[i]; e.halt = m_halt[i];
          exp_q[i].push_back(e);
          ref_q[i].push_back(r);
          pushed[i]++;
          m_prev[i] = c.order;
          m_have_prev[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    core_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ref_valid[i] = 1'b0; auto_on[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete(); ref_q[i].delete();
      m_prev[i] = '0; m_have_prev[i] = 1'b0; m_cnt[i] = 0; m_mism[i] = 1'b0;
      m_fields[i] = '0; m_order[i] = '0; m_halt[i] = 1'b0;
      pushed[i] = 0; popped[i] = 0; req_cnt[i] = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 0, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic responder(input int i);
    rvfi_cmp_entry_t r;
    forever begin
      @(negedge clk);
      if (auto_on[i] && ref_req[i] === 1'b1 && !rst) begin
        if (ref_q[i].size() == 0) begin
          check("ref_queue_empty", i, 64'd1, 64'd0);
        end else begin
          r = ref_q[i].pop_front();
          repeat (1 + $urandom_range(0, 2)) @(negedge clk);
          ref_pc[i] = r.pc; ref_insn[i] = r.insn; ref_rd_addr[i] = r.rd_addr;
          ref_rd_wdata[i] = r.rd_wdata; ref_trap[i] = r.trap;
          ref_valid[i] = 1'b1;
          @(negedge clk);
          ref_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial responder(0);
  initial responder(1);

  // Monitor: every compare completion pops the next expected outcome.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ref_req[i] === 1'b1) begin
        req_cnt[i]++;
        req_time[i] = $time;
        check("req_single_cycle", i, 64'(prev_req[i]), 64'd0);
      end
      prev_req[i] = ref_req[i];
      if (rst) begin
        last_cnt[i] = '0;
      end else if (cnt[i] !== last_cnt[i]) begin
        last_cnt[i] = cnt[i];
        if (exp_q[i].size() == 0) begin
          check("unexpected_compare", i, 64'(cnt[i]), 64'(m_cnt[i]));
        end else begin
          e = exp_q[i].pop_front();
          popped[i]++;
          check("cmp_count", i, 64'(cnt[i]), 64'(e.cnt));
          check("cmp_mismatch", i, 64'(mismatch[i]), 64'(e.mism));
          check("cmp_fields", i, 64'(mism_fields[i]), 64'(e.fields));
          check("cmp_order", i, mism_order[i], e.order);
          check("cmp_halted", i, 64'(halted[i]), 64'(e.halt));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog inst=0 actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rvfi_cmp_entry_t c;
    rvfi_cmp_entry_t r;
    logic [63:0] ord;
    int n;
    time t_to;

    rst = 1'b1; core_valid = 1'b0; core_order = '0; core_pc = '0; core_insn = '0;
    core_rd_addr = '0; core_rd_wdata = '0; core_trap = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ref_valid[i] = 1'b0; ref_pc[i] = '0; ref_insn[i] = '0; ref_rd_addr[i] = '0;
      ref_rd_wdata[i] = '0; ref_trap[i] = 1'b0; prev_req[i] = 1'b0; last_cnt[i] = '0;
    end
    do_reset();

    for (int i = 0; i < 2; i++) begin
      check("rst_outputs", i, {ref_req[i], mismatch[i], overflow[i], timeout[i], halted[i]}, 64'd0);
      check("rst_fields", i, 64'(mism_fields[i]), 64'd0);
      check("rst_cnt", i, 64'(cnt[i]), 64'd0);
      check("rst_order", i, mism_order[i], 64'd0);
    end

    // Three matching retirements.
    for (int k = 0; k < 3; k++) begin
      c = mk(64'(k + 1), 32'h80 + 32'(4 * k), 32'h0000_0013 + 32'(k), 5'd1, 32'(k), 1'b0);
      retire(c, c, 1'b1);
    end
    drain();
    for (int i = 0; i < 2; i++) begin
      check("t1_cnt", i, 64'(cnt[i]), 64'd3);
      check("t1_mismatch", i, 64'(mismatch[i]), 64'd0);
      check("t1_req_pulses", i, 64'(req_cnt[i]), 64'd3);
    end

    // rd_wdata differs on order 7.
    do_reset();
    c = mk(64'd5, 32'h100, 32'h13, 5'd3, 32'h9, 1'b0); retire(c, c, 1'b1);
    c = mk(64'd6, 32'h104, 32'h13, 5'd4, 32'h9, 1'b0); retire(c, c, 1'b1);
    c = mk(64'd7, 32'h108, 32'h0010_0293, 5'd5, 32'h1, 1'b0);
    r = c; r.rd_wdata = 32'h2;
    retire(c, r, 1'b1);
    drain();
    check("t2_fields", 0, 64'(mism_fields[0]), 64'b001000);
    check("t2_order", 0, mism_order[0], 64'd7);
    check("t2_halted", 0, 64'(halted[0]), 64'd1);
    check("t2_cont_running", 1, 64'(halted[1]), 64'd0);

    // x0 writes and double traps are masked.
    do_reset();
    c = mk(64'd1, 32'h200, 32'h13, 5'd0, 32'h11, 1'b0);
    r = c; r.rd_wdata = 32'h22;
    retire(c, r, 1'b1);
    c = mk(64'd2, 32'h204, 32'hDEAD_0001, 5'd7, 32'h33, 1'b1);
    r = c; r.insn = 32'hBEEF_0002; r.rd_addr = 5'd9; r.rd_wdata = 32'h44;
    retire(c, r, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) begin
      check("t3_mismatch", i, 64'(mismatch[i]), 64'd0);
      check("t3_cnt", i, 64'(cnt[i]), 64'd2);
    end

    // Overflow and timeout with the reference never answering.
    do_reset();
    auto_on[0] = 1'b0; auto_on[1] = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      c = mk(64'(k), 32'h300, 32'h13, 5'd1, 32'd0, 1'b0); retire(c, c, 1'b0);
    end
    check("t4_no_overflow_at_depth", 0, 64'(overflow[0]), 64'd0);
    for (int k = 0; k < 2; k++) begin
      c = mk(64'(k + 8), 32'h300, 32'h13, 5'd1, 32'd0, 1'b0); retire(c, c, 1'b0);
    end
    for (int i = 0; i < 2; i++) check("t4_overflow", i, 64'(overflow[i]), 64'd1);
    n = 0;
    while (timeout[0] !== 1'b1 && n < int'(TIMEOUT) + 50) begin
      @(negedge clk);
      n++;
    end
    t_to = $time;
    for (int i = 0; i < 2; i++) begin
      check("t4_timeout", i, 64'(timeout[i]), 64'd1);
      check("t4_halted", i, 64'(halted[i]), 64'd1);
      check("t4_cnt", i, 64'(cnt[i]), 64'd0);
    end
    check("t4_wait_cycles", 0, 64'((t_to - req_time[0]) / 10), 64'(TIMEOUT + 1));
    repeat (10) @(negedge clk);
    check("t4_single_req", 0, 64'(req_cnt[0]), 64'd1);

    // Order gap, then a pc mismatch: continue instance keeps the first fields.
    do_reset();
    c = mk(64'd4, 32'h400, 32'h13, 5'd2, 32'h5, 1'b0); retire(c, c, 1'b1);
    c = mk(64'd6, 32'h404, 32'h13, 5'd2, 32'h6, 1'b0); retire(c, c, 1'b1);
    c = mk(64'd7, 32'h408, 32'h13, 5'd2, 32'h7, 1'b0);
    r = c; r.pc = 32'h40C;
    retire(c, r, 1'b1);
    drain();
    check("t5_fields", 1, 64'(mism_fields[1]), 64'b100000);
    check("t5_order", 1, mism_order[1], 64'd6);
    check("t5_cnt", 1, 64'(cnt[1]), 64'd3);
    check("t5_running", 1, 64'(halted[1]), 64'd0);
    check("t5_cnt_stop", 0, 64'(cnt[0]), 64'd2);

    // Reset while waiting; a late reference record must be ignored.
    do_reset();
    auto_on[0] = 1'b0; auto_on[1] = 1'b0;
    c = mk(64'd1, 32'h500, 32'h13, 5'd1, 32'd1, 1'b0);
    retire(c, c, 1'b0);
    n = 0;
    while (req_cnt[0] == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_req_seen", 0, 64'(req_cnt[0]), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_cnt[0] = 0; req_cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      ref_pc[i] = 32'h999; ref_insn[i] = '0; ref_rd_addr[i] = '0; ref_rd_wdata[i] = '0;
      ref_trap[i] = 1'b0; ref_valid[i] = 1'b1;
    end
    @(negedge clk);
    ref_valid[0] = 1'b0; ref_valid[1] = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("t6_flags", i, {ref_req[i], mismatch[i], overflow[i], timeout[i], halted[i]}, 64'd0);
      check("t6_cnt", i, 64'(cnt[i]), 64'd0);
      check("t6_fields", i, 64'(mism_fields[i]), 64'd0);
      check("t6_no_req", i, 64'(req_cnt[i]), 64'd0);
    end

    // Randomized stream with occasional corruption and order gaps.
    do_reset();
    ord = 64'd100;
    for (int k = 0; k < 40; k++) begin
      n = 0;
      while (pushed[1] - popped[1] >= int'(DEPTH) - 2 && n < 500) begin
        @(negedge clk);
        n++;
      end
      ord = ord + (($urandom_range(0, 9) == 0) ? 64'd2 : 64'd1);
      c = mk(ord, $urandom & 32'hFFFF_FFFC, $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, ($urandom_range(0, 7) == 0));
      r = c;
      if (c.trap && $urandom_range(0, 1) == 1) r.insn = $urandom;
      case ($urandom_range(0, 11))
        0: r.pc = r.pc ^ 32'h4;
        1: r.insn = r.insn ^ (32'h1 << $urandom_range(0, 31));
        2: r.rd_addr = r.rd_addr ^ 5'h1;
        3: r.rd_wdata = r.rd_wdata ^ 32'h10;
        4: r.trap = ~r.trap;
        default: ;
      endcase
      retire(c, r, 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 2; i++) begin
      check("rnd_cnt", i, 64'(cnt[i]), 64'(m_cnt[i]));
      check("rnd_mismatch", i, 64'(mismatch[i]), 64'(m_mism[i]));
      check("rnd_halted", i, 64'(halted[i]), 64'(m_halt[i]));
    end
    check("rnd_no_overflow", 1, 64'(overflow[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
